// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans WIDTH-bit operands one CHUNK-bit
// slice per cycle from the MSB slice, stopping at the first differing slice.
module seq_magnitude_comparator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             a_less_b,
  output logic             a_gt_b
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : g_bad_chunk
      $fatal(1, "seq_magnitude_comparator: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  msb_flip;
  logic [WIDTH-1:0]  sh_a, sh_b;
  logic [CHUNK-1:0]  sl_a, sl_b;

  // Flipping the sign bit turns a two's-complement ordering into an unsigned one.
  always_comb begin
    msb_flip            = '0;
    msb_flip[WIDTH-1]   = signed_mode;
  end

  always_comb begin
    sh_a = a_q >> (CHUNK * idx_q);
    sh_b = b_q >> (CHUNK * idx_q);
    sl_a = sh_a[CHUNK-1:0];
    sl_b = sh_b[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if ((sl_a != sl_b) || (idx_q == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // idx is frozen on the deciding slice, so DONE re-derives the flags from it
  // and publishes them together with the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      eq       <= 1'b0;
      a_less_b <= 1'b0;
      a_gt_b   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE) || (state_q == DONE);
      done    <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= A ^ msb_flip;
            b_q      <= B ^ msb_flip;
            idx_q    <= IDXW'(N - 1);
            eq       <= 1'b0;
            a_less_b <= 1'b0;
            a_gt_b   <= 1'b0;
          end
        end
        SCAN: begin
          if ((sl_a == sl_b) && (idx_q != '0)) idx_q <= idx_q - 1'b1;
        end
        DONE: begin
          eq       <= (sl_a == sl_b);
          a_less_b <= (sl_a <  sl_b);
          a_gt_b   <= (sl_a >  sl_b);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomised self-checking bench for seq_magnitude_comparator (WIDTH=32, CHUNK=4).
module tb_seq_magnitude_comparator;

  localparam int unsigned W = 32;
  localparam int unsigned C = 4;
  localparam int unsigned N = W / C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, eq, a_less_b, a_gt_b;
  logic [2:0]   flags;

  int checks = 0;
  int errors = 0;

  assign flags = {eq, a_less_b, a_gt_b};

  seq_magnitude_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy), .done(done),
    .eq(eq), .a_less_b(a_less_b), .a_gt_b(a_gt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected flags {eq, lt, gt} from plain integer ordering.
  function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    logic lt;
    if (a == b) return 3'b100;
    lt = sm ? ($signed(a) < $signed(b)) : (a < b);
    return lt ? 3'b010 : 3'b001;
  endfunction

  // Edges from the accepting edge to the edge after which done is visible.
  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    int p;
    d = a ^ b;
    if (d == '0) return N + 1;
    p = 0;
    for (int i = 0; i < W; i++) if (d[i]) p = i;
    return (N - p / C) + 1;
  endfunction

  function automatic logic [W-1:0] rand_b(input logic [W-1:0] a);
    case ($urandom_range(0, 3))
      0: return a;
      1: return $urandom;
      default: return a ^ ($urandom >> $urandom_range(0, 31));
    endcase
  endfunction

  // Call just after a rising edge with the DUT idle.
  task automatic run_cmp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm);
    int  lat;
    logic pre_ok;
    A = a; B = b; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pre_ok = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      A = $urandom; B = $urandom; signed_mode = ~sm;
      if (!(busy && flags == 3'b000)) pre_ok = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    if (lat == 0) check({tag, "_timeout"}, 0, 1);
    check({tag, "_pre"}, pre_ok, 1);
    check({tag, "_lat"}, lat, ref_lat(a, b));
    check({tag, "_flags"}, flags, ref_flags(a, b, sm));
    check({tag, "_busy"}, busy, 1);
  endtask

  initial begin
    int dones;
    logic [2:0] got_flags;
    logic saw_done;
    logic [W-1:0] na, nb;
    logic nsm;
    int lat;

    #1;
    check("async_rst", {busy, done, flags}, 0);
    #11;
    check("rst_hold", {busy, done, flags}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Equal operands, then result must hold while idle
    run_cmp("eq", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy || flags != 3'b100) saw_done = 1'b1;
    end
    check("eq_hold", saw_done, 0);

    run_cmp("msb_u", 32'h80000000, 32'h7FFFFFFF, 1'b0);
    @(posedge clk); #1;
    run_cmp("msb_s", 32'h80000000, 32'h7FFFFFFF, 1'b1);
    @(posedge clk); #1;
    run_cmp("lsb_u", 32'h12345678, 32'h12345679, 1'b0);
    @(posedge clk); #1;
    run_cmp("lsb_s", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    @(posedge clk); #1;
    check("lsb_s_idle", busy, 0);

    // Start during SCAN and operand churn must not disturb the compare
    A = 5; B = 9; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; got_flags = '0;
    for (int i = 0; i < 30; i++) begin
      if (i == 1) begin start = 1'b1; A = 9; B = 5; end
      else begin start = 1'b0; A = $urandom; B = $urandom; end
      @(posedge clk); #1;
      if (done) begin dones++; got_flags = flags; end
    end
    check("ign_dones", dones, 1);
    check("ign_flags", got_flags, 3'b010);
    check("ign_idle", busy, 0);

    // Asynchronous reset during the third SCAN cycle
    A = 32'hCAFEF00D; B = 32'hCAFEF00D; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst", {busy, done, flags}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("mid_nodone", saw_done, 0);
    run_cmp("post_rst", 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;

    // Back-to-back with start held high
    na = $urandom; nb = rand_b(na); nsm = 1'($urandom);
    A = na; B = nb; signed_mode = nsm; start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;          // accepting edge
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
        A = $urandom; B = $urandom; signed_mode = 1'($urandom);
        @(posedge clk); #1;
        if (done) begin lat = i; break; end
      end
      if (lat == 0) begin
        check("b2b_timeout", 0, 1);
        break;
      end
      check("b2b_lat", lat, ref_lat(na, nb));
      check("b2b_flags", flags, ref_flags(na, nb, nsm));
      check("b2b_onehot", $countones(flags), 1);
      na = $urandom; nb = rand_b(na); nsm = 1'($urandom);
      A = na; B = nb; signed_mode = nsm;
    end
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator for wide operands, for use where a flat WIDTH-bit compare would not meet timing.
- Compares two WIDTH-bit operands one CHUNK-bit slice per cycle, starting at the MSB slice.
- Terminates early at the first differing slice.
- Supports unsigned and two's-complement signed modes.
- Uses a start/busy/done handshake and holds the result until the next accepted start.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits compared per cycle; CHUNK == WIDTH gives a single-slice compare.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a compare; sampled only in IDLE.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start.
A  input  WIDTH  operand A; latched with start.
B  input  WIDTH  operand B; latched with start.
busy  output  1  high in SCAN and DONE.
done  output  1  one-cycle pulse in DONE; the result is valid from this cycle.
eq  output  1  A == B.
a_less_b  output  1  A < B.
a_gt_b  output  1  A > B.

Behaviour:
- Reset (asynchronous, active-high):
  - The state machine goes to IDLE immediately.
  - busy, done, eq, a_less_b and a_gt_b all go to 0.
  - Latched operands and the slice index are cleared.
  - A reset during SCAN or DONE aborts the compare; no done is produced.
- Elaboration: WIDTH % CHUNK != 0 must be a fatal elaboration error. Define N = WIDTH / CHUNK.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On start = 1, latch A, B and signed_mode, set the slice index to N-1 (MSB slice), clear eq, a_less_b and a_gt_b, and go to SCAN.
  - On start = 0, stay in IDLE.
- Signed mode: at latch time, invert bit WIDTH-1 of both latched operands. An unsigned compare of the modified values then gives the signed ordering. No other signed logic is permitted.
- SCAN: each cycle, compare latched slice [idx*CHUNK +: CHUNK] of A against the same slice of B.
  - Slices differ: set a_gt_b or a_less_b according to the unsigned slice compare, then go to DONE.
  - Slices equal and idx == 0: set eq = 1, then go to DONE.
  - Slices equal and idx > 0: decrement idx and stay in SCAN.
- DONE: done = 1 for exactly this cycle, then go to IDLE. busy stays 1 in DONE.
- Latency: let start be sampled at edge 0 and k (1..N) be the 1-based position of the first differing slice, counted from the MSB.
  - done is high in the cycle after edge k+1.
  - For equal operands, k = N.
  - Worst case is N+1 cycles; best case (MSB slice differs) is 2.
- Result outputs:
  - Exactly one of eq, a_less_b, a_gt_b is 1 from done until the next accepted start.
  - All three are 0 while busy before done, and after reset.
- start during SCAN or DONE is ignored; the in-flight compare and its result are unaffected.
- Changes to A, B or signed_mode after acceptance have no effect until the next accepted start.
- start held high continuously: a new compare is accepted on each return to IDLE, one cycle after done.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
(All cases use WIDTH=32, CHUNK=4.)
1. Equal operands: A = B = 0xDEADBEEF, unsigned, one-cycle start → done 9 cycles after the start edge; eq = 1, a_less_b = 0, a_gt_b = 0; values held for 20 idle cycles afterwards.
2. Unsigned vs signed on the MSB slice: A = 0x80000000, B = 0x7FFFFFFF.
   - Unsigned → a_gt_b = 1 at 2-cycle latency.
   - Repeated with signed_mode = 1 → a_less_b = 1 at 2-cycle latency.
3. LSB-slice difference: A = 0x12345678, B = 0x12345679, unsigned → a_less_b = 1 at 9-cycle latency. Separately, A = 0xFFFFFFFF, B = 0xFFFFFFFE, signed → a_gt_b = 1 at 9-cycle latency.
4. Ignored start and operand changes: start with A = 5, B = 9, then pulse start with A = 9, B = 5 during SCAN, and change A/B every cycle → result is a_less_b = 1; exactly one done pulse; the second start is not queued.
5. Reset mid-operation: assert rst asynchronously (mid-cycle) during the 3rd SCAN cycle → all outputs 0 before the next clock edge; no done appears. After rst is released, start with A = B = 0 → eq = 1 at 9-cycle latency.
6. Back-to-back starts: hold start high with random operand pairs for 1000 compares → each result matches a reference model, done pulses are spaced by latency + 1, and exactly one result flag is high at each done.
